im_boot_ctrl: RTL and testbench

Boot/load controller for the single-cycle CPU's byte-addressed, 2048-byte instruction memory. It owns the IM address/write port while a program is streamed in over a byte-wide valid/ready link, assembles little-endian 32-bit words, and writes them to consecutive word addresses from 0. It holds the CPU stalled until the load completes, then hands the IM address port to the CPU fetch PC and asserts `cpu_run`.

---
 rtl/im_boot_ctrl.sv | 153 +++++++++++++++
 tb/tb_im_boot_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_ctrl.sv
// im_boot_ctrl: streams a byte-wide program image into the 2048-byte
// instruction memory as little-endian words from address 0. The CPU stays
// stalled until the load completes, then the IM address port follows its PC.
module im_boot_ctrl #(
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [31:0] cpu_pc,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        im_we,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_byte_idx;
  logic [IDX_W-1:0]    r_word_idx;
  logic [IDX_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_asm;
  logic [DATA_W-1:0]   r_im_addr;
  logic [DATA_W-1:0]   r_im_wdata;
  logic                r_im_we;
  logic                r_in_ready;
  logic                r_cpu_run;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_count_ok;
  logic                w_handshake;
  logic [IDX_W-1:0]    w_word_next;

  // A load request is legal only for 1..DEPTH_WORDS words.
  assign w_count_ok  = (word_count != '0) && (32'(word_count) <= DEPTH_WORDS);
  assign w_handshake = in_valid && r_in_ready && (r_state == S_LOAD);
  assign w_word_next = r_word_idx + IDX_W'(1);

  // In RUN the fetch PC drives IM with no added latency.
  assign im_addr  = (r_state == S_RUN) ? cpu_pc : r_im_addr;
  assign im_wdata = r_im_wdata;
  assign im_we    = r_im_we;
  assign in_ready = r_in_ready;
  assign cpu_run  = r_cpu_run;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

  // Load controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_count    <= '0;
      r_asm      <= '0;
      r_im_addr  <= '0;
      r_im_wdata <= '0;
      r_im_we    <= 1'b0;
      r_in_ready <= 1'b0;
      r_cpu_run  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_im_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_im_addr <= '0;
          r_cpu_run <= 1'b0;
          if (start) begin
            if (w_count_ok) begin
              r_count    <= word_count;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_asm      <= '0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_handshake) begin
            r_asm[{r_byte_idx, 3'b000} +: BYTE_W] <= in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_in_ready <= 1'b0;
              r_im_we    <= 1'b1;
              r_im_addr  <= {20'b0, r_word_idx, 2'b00};
              r_im_wdata <= {in_data, r_asm[23:0]};
              r_state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_word_idx <= w_word_next;
          if (w_word_next == r_count) begin
            r_done    <= 1'b1;
            r_cpu_run <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_RUN;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_RUN: begin
          if (start) begin
            if (w_count_ok) begin
              r_count    <= word_count;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_asm      <= '0;
              r_im_addr  <= '0;
              r_cpu_run  <= 1'b0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_boot_ctrl.sv
// Directed bench for im_boot_ctrl: loads, stalls, rejects, restarts, reset.
module tb_im_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] cpu_pc;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        im_we;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  im_boot_ctrl #(.DEPTH_WORDS(512)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_pc(cpu_pc), .im_addr(im_addr), .im_wdata(im_wdata), .im_we(im_we),
    .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // IM write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic start_pulse(input logic [9:0] wc);
    start = 1'b1;
    word_count = wc;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until accepted; returns one cycle after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] wv;
    wv = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(wv[8*i +: 8]);
      if (gap) begin
        if (i < 3) begin
          n_vec++;
          if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL gap_in_ready: got %b want 1", in_ready);
          end
        end
        tick();
      end
    end
  endtask

  task automatic check_log2(input logic [31:0] d0, input logic [31:0] d1);
    n_vec++;
    if (wr_addr.size() !== 2) begin
      n_err++;
      $display("FAIL log_size: got %0d want 2", wr_addr.size());
    end else begin
      n_vec++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== d0) begin
        n_err++;
        $display("FAIL log_w0: got %h@%h want %h@0", wr_data[0], wr_addr[0], d0);
      end
      n_vec++;
      if (wr_addr[1] !== 32'h4 || wr_data[1] !== d1) begin
        n_err++;
        $display("FAIL log_w1: got %h@%h want %h@4", wr_data[1], wr_addr[1], d1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++;
    if ({in_ready, im_we, cpu_run, busy, done, err} !== 6'b0 || im_addr !== 32'h0 || im_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b we=%b run=%b busy=%b done=%b err=%b addr=%h wdata=%h want all 0",
               in_ready, im_we, cpu_run, busy, done, err, im_addr, im_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_err_idle(input logic [9:0] wc);
    clear_log();
    start_pulse(wc);
    n_vec++;
    if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || cpu_run !== 1'b0) begin
      n_err++;
      $display("FAIL err_idle_pulse wc=%0d: err=%b rdy=%b busy=%b run=%b want 1 0 0 0", wc, err, in_ready, busy, cpu_run);
    end
    tick();
    n_vec++;
    if (err !== 1'b0 || in_ready !== 1'b0 || im_addr !== 32'h0) begin
      n_err++;
      $display("FAIL err_idle_after wc=%0d: err=%b rdy=%b addr=%h want 0 0 0", wc, err, in_ready, im_addr);
    end
    tick();
    n_vec++;
    if (wr_addr.size() !== 0) begin
      n_err++;
      $display("FAIL err_idle_no_write wc=%0d: got %0d writes want 0", wc, wr_addr.size());
    end
  endtask

  task automatic test_load_held();
    clear_log();
    start_pulse(10'd2);
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL load_enter: rdy=%b busy=%b want 1 1", in_ready, busy);
    end
    send_word(32'h34040001, 1'b0);
    send_word(32'h34050001, 1'b0);
    n_vec++;
    if (im_we !== 1'b1 || im_addr !== 32'h4 || im_wdata !== 32'h34050001 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL load_last_write: we=%b addr=%h data=%h rdy=%b want 1 4 34050001 0", im_we, im_addr, im_wdata, in_ready);
    end
    tick();
    n_vec++;
    if (done !== 1'b1 || cpu_run !== 1'b1 || busy !== 1'b0 || im_we !== 1'b0) begin
      n_err++;
      $display("FAIL load_done: done=%b run=%b busy=%b we=%b want 1 1 0 0", done, cpu_run, busy, im_we);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL load_done_drop: done=%b run=%b want 0 1", done, cpu_run);
    end
    check_log2(32'h34040001, 32'h34050001);
  endtask

  task automatic test_load_toggle();
    int waited;
    clear_log();
    start_pulse(10'd2);
    n_vec++;
    if (cpu_run !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL toggle_enter: run=%b rdy=%b want 0 1", cpu_run, in_ready);
    end
    send_word(32'h34040001, 1'b1);
    send_word(32'h34050001, 1'b1);
    waited = 0;
    while (cpu_run !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_vec++;
    if (cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL toggle_run: got %b want 1", cpu_run);
    end
    tick();
    check_log2(32'h34040001, 32'h34050001);
  endtask

  task automatic test_run();
    clear_log();
    cpu_pc = 32'h20;
    #1;
    n_vec++;
    if (im_addr !== 32'h20 || im_we !== 1'b0 || cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL run_pc20: addr=%h we=%b run=%b want 20 0 1", im_addr, im_we, cpu_run);
    end
    cpu_pc = 32'h0000_0144;
    #1;
    n_vec++;
    if (im_addr !== 32'h144) begin
      n_err++;
      $display("FAIL run_pc_follow: addr=%h want 144", im_addr);
    end
    start_pulse(10'd0);
    n_vec++;
    if (err !== 1'b1 || cpu_run !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL run_err: err=%b run=%b rdy=%b want 1 1 0", err, cpu_run, in_ready);
    end
    tick();
    start_pulse(10'd1);
    n_vec++;
    if (cpu_run !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL run_restart: run=%b rdy=%b busy=%b want 0 1 1", cpu_run, in_ready, busy);
    end
    send_word(32'hDEADBEEF, 1'b0);
    n_vec++;
    if (im_we !== 1'b1 || im_addr !== 32'h0 || im_wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL run_reload_write: we=%b addr=%h data=%h want 1 0 deadbeef", im_we, im_addr, im_wdata);
    end
    tick();
    n_vec++;
    if (done !== 1'b1 || cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL run_reload_done: done=%b run=%b want 1 1", done, cpu_run);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    clear_log();
    start_pulse(10'd3);
    send_word(32'h11223344, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    tick();
    n_vec++;
    if ({in_ready, im_we, cpu_run, busy, done, err} !== 6'b0 || im_addr !== 32'h0 || im_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_outputs: rdy=%b we=%b run=%b busy=%b done=%b err=%b addr=%h wdata=%h want all 0",
               in_ready, im_we, cpu_run, busy, done, err, im_addr, im_wdata);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    tick(); tick(); tick();
    in_valid = 1'b0;
    n_vec++;
    if (wr_addr.size() !== 1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_partial: writes=%0d rdy=%b want 1 0", wr_addr.size(), in_ready);
    end
    clear_log();
    start_pulse(10'd2);
    send_word(32'h0A0B0C0D, 1'b0);
    send_word(32'hF0E0D0C0, 1'b0);
    tick(); tick();
    n_vec++;
    if (cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_reload_run: got %b want 1", cpu_run);
    end
    check_log2(32'h0A0B0C0D, 32'hF0E0D0C0);
  endtask

  task automatic test_full();
    clear_log();
    start_pulse(10'd512);
    for (int i = 0; i < 512; i++) begin
      send_word(32'hC0DE0000 | 32'(i), 1'b0);
    end
    n_vec++;
    if (im_we !== 1'b1 || im_addr !== 32'h7FC || im_wdata !== 32'hC0DE01FF) begin
      n_err++;
      $display("FAIL full_last_write: we=%b addr=%h data=%h want 1 7fc c0de01ff", im_we, im_addr, im_wdata);
    end
    tick();
    n_vec++;
    if (done !== 1'b1 || cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL full_done: done=%b run=%b want 1 1", done, cpu_run);
    end
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (6) tick();
    in_valid = 1'b0;
    n_vec++;
    if (wr_addr.size() !== 512) begin
      n_err++;
      $display("FAIL full_count: got %0d writes want 512", wr_addr.size());
    end else begin
      for (int i = 0; i < 512; i++) begin
        n_vec++;
        if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== (32'hC0DE0000 | 32'(i))) begin
          n_err++;
          $display("FAIL full_word%0d: got %h@%h want %h@%h", i, wr_data[i], wr_addr[i],
                   32'hC0DE0000 | 32'(i), 32'(i * 4));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    word_count = '0;
    in_valid = 1'b0;
    in_data = '0;
    cpu_pc = '0;
    test_reset();
    test_err_idle(10'd0);
    test_err_idle(10'd513);
    test_load_held();
    test_run();
    test_load_toggle();
    test_mid_reset();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
